// File: rtl/hazard_controller_if.sv
// Datapath <-> hazard controller bundle: register indices, writeback/memory/MDU
// status from the pipeline, and the stall/flush/forward controls back to it.
interface hazard_controller_if #(
    parameter int PERF_W = 32
);
    logic [4:0]        Rs1D;
    logic [4:0]        Rs2D;
    logic [4:0]        Rs1E;
    logic [4:0]        Rs2E;
    logic [4:0]        RdE;
    logic [4:0]        RdM;
    logic [4:0]        RdW;
    logic              RegWriteM;
    logic              RegWriteW;
    logic              LoadE;
    logic              PCSrcE;
    logic              MduStartE;
    logic              MemReqM;
    logic              MemAckM;
    logic              StallF;
    logic              StallD;
    logic              StallE;
    logic              StallM;
    logic              FlushD;
    logic              FlushE;
    logic              FlushM;
    logic              FlushW;
    logic [1:0]        ForwardAE;
    logic [1:0]        ForwardBE;
    logic              MduDoneE;
    logic [PERF_W-1:0] StallCycles;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
               LoadE, PCSrcE, MduStartE, MemReqM, MemAckM,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
               ForwardAE, ForwardBE, MduDoneE, StallCycles
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
               LoadE, PCSrcE, MduStartE, MemReqM, MemAckM,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
               ForwardAE, ForwardBE, MduDoneE, StallCycles
    );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline sequencer for the 5-stage core: stall/flush generation for load-use,
// redirects, multi-cycle MDU ops and data-memory wait states, plus E-stage forwarding.
module hazard_controller #(
    parameter int MDU_LATENCY = 4,
    parameter int PERF_W      = 32
) (
    input  logic                clk,
    input  logic                rst,
    hazard_controller_if.slave  hz
);
    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MDU_BUSY = 2'd1;
    localparam logic [1:0] MEM_WAIT = 2'd2;

    localparam int              CNT_W    = $clog2(MDU_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MDU_LATENCY > 1) ? (MDU_LATENCY - 2) : 0);

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [CNT_W-1:0]  mdu_cnt_r;
    logic [CNT_W-1:0]  mdu_cnt_nxt_s;
    logic              ret_mdu_r;
    logic              ret_mdu_nxt_s;
    logic [PERF_W-1:0] stall_cycles_r;

    logic stall_f_s, stall_d_s, stall_e_s, stall_m_s;
    logic flush_d_s, flush_e_s, flush_m_s, flush_w_s;
    logic mdu_done_s;
    logic mem_wait_s;
    logic load_use_s;

    // M-stage result is younger than W, so it wins when both match.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic wr_m,
                                           input logic [4:0] rd_m, input logic wr_w,
                                           input logic [4:0] rd_w);
        logic [1:0] sel;
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    assign mem_wait_s = hz.MemReqM && !hz.MemAckM;
    assign load_use_s = hz.LoadE && (hz.RdE != 5'd0) &&
                        ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

    // Next-state and control decode; freeze states ignore redirects and load-use.
    always_comb begin
        state_nxt_s   = state_r;
        mdu_cnt_nxt_s = mdu_cnt_r;
        ret_mdu_nxt_s = ret_mdu_r;
        stall_f_s = 1'b0; stall_d_s = 1'b0; stall_e_s = 1'b0; stall_m_s = 1'b0;
        flush_d_s = 1'b0; flush_e_s = 1'b0; flush_m_s = 1'b0; flush_w_s = 1'b0;
        mdu_done_s = 1'b0;
        case (state_r)
            RUN: begin
                if (mem_wait_s) begin
                    {stall_f_s, stall_d_s, stall_e_s, stall_m_s, flush_w_s} = 5'b11111;
                    ret_mdu_nxt_s = 1'b0;
                    state_nxt_s   = MEM_WAIT;
                end else if (hz.MduStartE) begin
                    if (MDU_LATENCY > 1) begin
                        {stall_f_s, stall_d_s, stall_e_s, flush_m_s} = 4'b1111;
                        mdu_cnt_nxt_s = CNT_LOAD;
                        state_nxt_s   = MDU_BUSY;
                    end else begin
                        mdu_done_s = 1'b1;
                    end
                end else if (load_use_s) begin
                    {stall_f_s, stall_d_s, flush_e_s} = 3'b111;
                end else if (hz.PCSrcE) begin
                    {flush_d_s, flush_e_s} = 2'b11;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            MDU_BUSY: begin
                if (mem_wait_s) begin
                    {stall_f_s, stall_d_s, stall_e_s, stall_m_s, flush_w_s} = 5'b11111;
                    ret_mdu_nxt_s = 1'b1;
                    state_nxt_s   = MEM_WAIT;
                end else if (mdu_cnt_r == {CNT_W{1'b0}}) begin
                    mdu_done_s  = 1'b1;
                    state_nxt_s = RUN;
                end else begin
                    {stall_f_s, stall_d_s, stall_e_s, flush_m_s} = 4'b1111;
                    mdu_cnt_nxt_s = mdu_cnt_r - CNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (hz.MemAckM) begin
                    // The memory stage is released, but an interrupted MDU op still owns E.
                    if (ret_mdu_r) begin
                        {stall_f_s, stall_d_s, stall_e_s, flush_m_s} = 4'b1111;
                        state_nxt_s = MDU_BUSY;
                    end else begin
                        state_nxt_s = RUN;
                    end
                    ret_mdu_nxt_s = 1'b0;
                end else begin
                    {stall_f_s, stall_d_s, stall_e_s, stall_m_s, flush_w_s} = 5'b11111;
                end
            end
            default: begin
                state_nxt_s   = RUN;
                ret_mdu_nxt_s = 1'b0;
            end
        endcase
    end

    // FSM, MDU countdown and return flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= RUN;
            mdu_cnt_r <= {CNT_W{1'b0}};
            ret_mdu_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            mdu_cnt_r <= mdu_cnt_nxt_s;
            ret_mdu_r <= ret_mdu_nxt_s;
        end
    end

    // Stall-cycle performance counter; wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_r <= {PERF_W{1'b0}};
        end else if (stall_f_s) begin
            stall_cycles_r <= stall_cycles_r + PERF_W'(1);
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

    assign hz.StallF      = !rst && stall_f_s;
    assign hz.StallD      = !rst && stall_d_s;
    assign hz.StallE      = !rst && stall_e_s;
    assign hz.StallM      = !rst && stall_m_s;
    assign hz.FlushD      = !rst && flush_d_s;
    assign hz.FlushE      = !rst && flush_e_s;
    assign hz.FlushM      = !rst && flush_m_s;
    assign hz.FlushW      = !rst && flush_w_s;
    assign hz.MduDoneE    = !rst && mdu_done_s;
    assign hz.ForwardAE   = rst ? 2'b00 : fwd_sel(hz.Rs1E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
    assign hz.ForwardBE   = rst ? 2'b00 : fwd_sel(hz.Rs2E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
    assign hz.StallCycles = stall_cycles_r;
endmodule

// File: tb/tb_hazard_controller.sv
// Hazard controller bench: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural pipeline model.
module tb_hazard_controller;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_controller_if #(.PERF_W(32)) hz ();
    hazard_controller_if #(.PERF_W(3))  hs ();

    hazard_controller #(.MDU_LATENCY(LAT), .PERF_W(32)) dut   (.clk(clk), .rst(rst), .hz(hz));
    hazard_controller #(.MDU_LATENCY(LAT), .PERF_W(3))  dut_s (.clk(clk), .rst(rst), .hz(hs));

    assign hs.Rs1D = hz.Rs1D;  assign hs.Rs2D = hz.Rs2D;
    assign hs.Rs1E = hz.Rs1E;  assign hs.Rs2E = hz.Rs2E;
    assign hs.RdE  = hz.RdE;   assign hs.RdM  = hz.RdM;   assign hs.RdW = hz.RdW;
    assign hs.RegWriteM = hz.RegWriteM;  assign hs.RegWriteW = hz.RegWriteW;
    assign hs.LoadE = hz.LoadE;  assign hs.PCSrcE = hz.PCSrcE;
    assign hs.MduStartE = hz.MduStartE;
    assign hs.MemReqM = hz.MemReqM;  assign hs.MemAckM = hz.MemAckM;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: remaining E-cycles of the current MDU op (incl. the done cycle) and
    // whether the pipeline is parked waiting on data memory.
    int          m_mdu_left = 0;
    bit          m_mem      = 1'b0;
    longint      m_cnt      = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (hz.RegWriteM && hz.RdM != 5'd0 && hz.RdM == rs) return 2'b10;
        if (hz.RegWriteW && hz.RdW != 5'd0 && hz.RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Per-cycle compare against the model, then advance the model past the coming edge.
    always @(negedge clk) begin
        bit sf, sd, se, sm, fd, fe, fm, fw, dn;
        logic [1:0] fa, fb;
        bit mw;
        {sf, sd, se, sm, fd, fe, fm, fw, dn} = '0;
        fa = 2'b00; fb = 2'b00;
        if (rst) begin
            m_mdu_left = 0; m_mem = 1'b0; m_cnt = 0;
        end else begin
            fa = m_fwd(hz.Rs1E);
            fb = m_fwd(hz.Rs2E);
            mw = hz.MemReqM && !hz.MemAckM;
            if (m_mem) begin
                if (hz.MemAckM) begin
                    m_mem = 1'b0;
                    if (m_mdu_left > 0) {sf, sd, se, fm} = 4'hF;
                end else begin
                    {sf, sd, se, sm, fw} = 5'h1F;
                end
            end else if (m_mdu_left > 0) begin
                if (mw) begin
                    {sf, sd, se, sm, fw} = 5'h1F; m_mem = 1'b1;
                end else if (m_mdu_left == 1) begin
                    dn = 1'b1; m_mdu_left = 0;
                end else begin
                    {sf, sd, se, fm} = 4'hF; m_mdu_left--;
                end
            end else if (mw) begin
                {sf, sd, se, sm, fw} = 5'h1F; m_mem = 1'b1;
            end else if (hz.MduStartE) begin
                {sf, sd, se, fm} = 4'hF; m_mdu_left = LAT - 1;
            end else if (hz.LoadE && hz.RdE != 5'd0 && (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D)) begin
                {sf, sd, fe} = 3'b111;
            end else if (hz.PCSrcE) begin
                {fd, fe} = 2'b11;
            end
        end
        chk("ctrl", {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE,
                     hz.FlushM, hz.FlushW, hz.MduDoneE, hz.ForwardAE, hz.ForwardBE},
                    {sf, sd, se, sm, fd, fe, fm, fw, dn, fa, fb});
        chk("stall_cycles", 64'(hz.StallCycles), 64'(m_cnt[31:0]));
        chk("stall_cycles_w3", 64'(hs.StallCycles), 64'(m_cnt[2:0]));
        if (!rst) m_cnt = m_cnt + longint'(sf);
    end

    task automatic clr();
        hz.Rs1D = 5'd0; hz.Rs2D = 5'd0; hz.Rs1E = 5'd0; hz.Rs2E = 5'd0;
        hz.RdE = 5'd0; hz.RdM = 5'd0; hz.RdW = 5'd0;
        hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0; hz.LoadE = 1'b0; hz.PCSrcE = 1'b0;
        hz.MduStartE = 1'b0; hz.MemReqM = 1'b0; hz.MemAckM = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    task automatic adv();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; adv(); adv(); rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clr();
        settle();
        chk("rst_stallf", 64'(hz.StallF), 64'd0);
        chk("rst_count", 64'(hz.StallCycles), 64'd0);
        adv(); rst = 1'b0;

        // Load-use on x5, then the same with x0.
        hz.LoadE = 1'b1; hz.RdE = 5'd5; hz.Rs1D = 5'd5; settle();
        chk("lu_stall", 64'({hz.StallF, hz.StallD, hz.FlushE}), 64'b111);
        adv(); hz.RdE = 5'd0; hz.Rs1D = 5'd0; settle();
        chk("lu_x0", 64'({hz.StallF, hz.StallD, hz.FlushE}), 64'b000);
        adv(); clr();

        // Forwarding priority.
        hz.RdM = 5'd7; hz.RdW = 5'd7; hz.RegWriteM = 1'b1; hz.RegWriteW = 1'b1; hz.Rs1E = 5'd7;
        settle(); chk("fwd_m", 64'(hz.ForwardAE), 64'b10);
        adv(); hz.RegWriteM = 1'b0; settle(); chk("fwd_w", 64'(hz.ForwardAE), 64'b01);
        adv(); clr();

        // MDU op: three stall cycles, done in the fourth.
        do_reset();
        hz.MduStartE = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("mdu_stall", 64'(hz.StallF), 64'(i < 3));
            chk("mdu_done", 64'(hz.MduDoneE), 64'(i == 3));
            adv();
        end
        hz.MduStartE = 1'b0; settle();
        chk("mdu_count", 64'(hz.StallCycles), 64'd3);
        adv();

        // Memory wait while the MDU countdown is at 1.
        do_reset();
        hz.MduStartE = 1'b1; adv(); adv();
        hz.MemReqM = 1'b1; settle(); chk("mw_stallm0", 64'(hz.StallM), 64'd1);
        adv(); settle(); chk("mw_stallm1", 64'(hz.StallM), 64'd1);
        adv(); hz.MemAckM = 1'b1; settle();
        chk("mw_ack", 64'({hz.StallF, hz.StallM, hz.MduDoneE}), 64'b100);
        adv(); hz.MemReqM = 1'b0; hz.MemAckM = 1'b0; settle();
        chk("mw_ret", 64'({hz.StallF, hz.MduDoneE}), 64'b10);
        adv(); settle(); chk("mw_done", 64'(hz.MduDoneE), 64'd1);
        adv(); clr();

        // Redirect held during a memory wait.
        do_reset();
        hz.MemReqM = 1'b1; hz.PCSrcE = 1'b1; settle();
        chk("br_hold0", 64'({hz.FlushD, hz.FlushE, hz.StallM}), 64'b001);
        adv(); settle(); chk("br_hold1", 64'({hz.FlushD, hz.FlushE}), 64'b00);
        adv(); hz.MemAckM = 1'b1; settle();
        chk("br_rel", 64'({hz.FlushD, hz.FlushE, hz.StallF}), 64'b000);
        adv(); hz.MemReqM = 1'b0; hz.MemAckM = 1'b0; settle();
        chk("br_flush", 64'({hz.FlushD, hz.FlushE}), 64'b11);
        adv(); clr();

        // Reset in the middle of an MDU op.
        do_reset();
        hz.MduStartE = 1'b1; adv(); adv();
        rst = 1'b1; settle();
        chk("rst_mid", 64'({hz.StallF, hz.MduDoneE}), 64'b00);
        chk("rst_mid_cnt", 64'(hz.StallCycles), 64'd0);
        adv(); rst = 1'b0; hz.MduStartE = 1'b0; settle();
        chk("rst_nodone", 64'({hz.StallF, hz.MduDoneE}), 64'b00);
        adv();

        // Counter wrap on the 3-bit instance: 9 stall cycles -> 1.
        do_reset();
        hz.MemReqM = 1'b1;
        for (int i = 0; i < 9; i++) adv();
        hz.MemReqM = 1'b0; settle();
        chk("wrap_w3", 64'(hs.StallCycles), 64'd1);
        chk("wrap_w32", 64'(hz.StallCycles), 64'd9);
        adv();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 99) == 0);
            hz.Rs1D      = 5'($urandom_range(0, 7));
            hz.Rs2D      = 5'($urandom_range(0, 7));
            hz.Rs1E      = 5'($urandom_range(0, 7));
            hz.Rs2E      = 5'($urandom_range(0, 7));
            hz.RdE       = 5'($urandom_range(0, 7));
            hz.RdM       = 5'($urandom_range(0, 7));
            hz.RdW       = 5'($urandom_range(0, 7));
            hz.RegWriteM = 1'($urandom_range(0, 1));
            hz.RegWriteW = 1'($urandom_range(0, 1));
            hz.LoadE     = ($urandom_range(0, 9) < 3);
            hz.PCSrcE    = !hz.LoadE && ($urandom_range(0, 9) < 2);
            hz.MduStartE = ($urandom_range(0, 9) == 0);
            hz.MemReqM   = ($urandom_range(0, 9) < 2);
            hz.MemAckM   = hz.MemReqM && ($urandom_range(0, 1) == 1);
            adv();
        end
        rst = 1'b0; clr(); adv(); settle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
